// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Round-robin contention with an r1 bus lock that has a watchdog timeout.
module mem_arbiter #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned LOCK_MAX = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_valid,
  input  logic [AW-1:0] r0_addr,
  output logic          r0_ready,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_valid,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic          r1_lock,
  output logic          r1_ready,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          lock_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_MAX - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          lock_mode_q, lock_mode_d;
  logic [15:0]   lock_cnt_q, lock_cnt_d;
  logic          lock_err_q, lock_err_d;
  logic          lock_ign_q, lock_ign_d;

  logic arb_point;
  logic lock_in;
  logic forced;
  logic gnt0, gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lock_mode_q <= 1'b0;
      lock_cnt_q  <= '0;
      lock_err_q  <= 1'b0;
      lock_ign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lock_mode_q <= lock_mode_d;
      lock_cnt_q  <= lock_cnt_d;
      lock_err_q  <= lock_err_d;
      lock_ign_q  <= lock_ign_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lock_mode_d = lock_mode_q;
    lock_cnt_d  = lock_cnt_q;
    lock_err_d  = lock_err_q;
    lock_ign_d  = lock_ign_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;

    arb_point = (state_q == IDLE) || (state_q == RESP);
    // After a forced release r1_lock is masked until r1 lets go of it.
    lock_in   = r1_lock && !lock_ign_q;
    forced    = lock_mode_q && (lock_cnt_q == LOCK_LAST);

    // rst_n gating keeps ready low while reset is held, even in IDLE.
    if (rst_n && arb_point) begin
      if (lock_mode_q && lock_in) begin
        gnt1 = r1_valid;
      end else if (r0_valid && r1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = r0_valid;
        gnt1 = r1_valid;
      end
    end

    case (state_q)
      IDLE, RESP: state_d = (gnt0 || gnt1) ? ISSUE : IDLE;
      ISSUE:      state_d = RESP;
      default:    state_d = IDLE;
    endcase

    if (gnt0 || gnt1) begin
      owner_d = gnt1;
      last_d  = gnt1;
      addr_d  = gnt1 ? r1_addr : r0_addr;
      we_d    = gnt1 && r1_we;
      wdata_d = gnt1 ? r1_wdata : '0;
    end

    if (arb_point && lock_mode_q && !lock_in) begin
      lock_mode_d = 1'b0;
    end
    if (gnt1 && lock_in) begin
      lock_mode_d = 1'b1;
    end

    if (!r1_lock) begin
      lock_ign_d = 1'b0;
    end

    if (lock_mode_q) begin
      lock_cnt_d = lock_cnt_q + 16'd1;
    end
    // The watchdog wins over any lock request made in the same cycle.
    if (forced) begin
      lock_mode_d = 1'b0;
      lock_err_d  = 1'b1;
      lock_ign_d  = 1'b1;
    end
    if (!lock_mode_d) begin
      lock_cnt_d = '0;
    end
  end

  always_comb begin
    r0_ready  = gnt0;
    r1_ready  = gnt1;
    mem_en    = (state_q == ISSUE);
    mem_we    = mem_en && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    r0_rvalid = (state_q == RESP) && !owner_q;
    r1_rvalid = (state_q == RESP) && owner_q;
    r0_rdata  = r0_rvalid ? mem_rdata : '0;
    r1_rdata  = (r1_rvalid && !we_q) ? mem_rdata : '0;
    lock_err  = lock_err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural sync RAM.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LM = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          r0_valid = 1'b0;
  logic [AW-1:0] r0_addr = '0;
  logic          r0_ready, r0_rvalid;
  logic [DW-1:0] r0_rdata;
  logic          r1_valid = 1'b0;
  logic          r1_we = 1'b0;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          r1_lock = 1'b0;
  logic          r1_ready, r1_rvalid;
  logic [DW-1:0] r1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          lock_err;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
  logic [DW-1:0] ram_q = '0;

  always #5 clk = ~clk;

  // RAM contents are preloaded on clock edges seen while reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      ram[16'h0010] <= 16'hBEEF;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_ready(r0_ready),
    .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_lock(r1_lock), .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lock_err(lock_err)
  );

  task automatic test_reset();
    #1 rst_n = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1; r0_addr = 16'h1111; r1_addr = 16'h2222;
    #1;
    total++; if ({r0_ready, r1_ready} !== 2'b00) begin bad++; $display("[TB] FAIL rst_ready got=%b want=00", {r0_ready, r1_ready}); end
    total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== 34'h0) begin bad++; $display("[TB] FAIL rst_mem got=%h want=0", {mem_en, mem_we, mem_addr, mem_wdata}); end
    total++; if ({r0_rvalid, r1_rvalid, lock_err} !== 3'b000) begin bad++; $display("[TB] FAIL rst_flags got=%b want=000", {r0_rvalid, r1_rvalid, lock_err}); end
    total++; if ({r0_rdata, r1_rdata} !== 32'h0) begin bad++; $display("[TB] FAIL rst_rdata got=%h want=0", {r0_rdata, r1_rdata}); end
    repeat (2) @(posedge clk);
    total++; if ({r0_ready, r1_ready, mem_en} !== 3'b000) begin bad++; $display("[TB] FAIL rst_held got=%b want=000", {r0_ready, r1_ready, mem_en}); end
    @(negedge clk);
    r0_valid = 1'b0; r1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_contention();
    logic want0;
    @(negedge clk);
    r0_valid = 1'b1; r0_addr = 16'h0100;
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 16'h0200; r1_lock = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      want0 = (k % 2 == 0);
      total++; if ({r0_ready, r1_ready} !== {want0, !want0}) begin bad++; $display("[TB] FAIL cont_grant%0d got=%b want=%b", k, {r0_ready, r1_ready}, {want0, !want0}); end
      if (k > 0) begin
        total++; if ({r0_rvalid, r1_rvalid} !== {!want0, want0}) begin bad++; $display("[TB] FAIL cont_rvalid%0d got=%b want=%b", k, {r0_rvalid, r1_rvalid}, {!want0, want0}); end
      end
      @(negedge clk); #1;
      total++; if ({r0_ready, r1_ready, mem_en, mem_addr} !== {3'b001, (want0 ? 16'h0100 : 16'h0200)}) begin bad++; $display("[TB] FAIL cont_issue%0d got=%h", k, {r0_ready, r1_ready, mem_en, mem_addr}); end
      @(negedge clk);
      if (k == 3) begin r0_valid = 1'b0; r1_valid = 1'b0; end
      #1;
    end
    total++; if ({r1_rvalid, r0_ready, r1_ready} !== 3'b100) begin bad++; $display("[TB] FAIL cont_last got=%b want=100", {r1_rvalid, r0_ready, r1_ready}); end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    r0_valid = 1'b1; r0_addr = 16'h0010; #1;
    total++; if ({r0_ready, r1_ready} !== 2'b10) begin bad++; $display("[TB] FAIL rd_accept got=%b want=10", {r0_ready, r1_ready}); end
    @(negedge clk);
    r0_valid = 1'b0; r0_addr = 16'h7777; #1;
    total++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'h0010}) begin bad++; $display("[TB] FAIL rd_issue got=%h want=%h", {mem_en, mem_we, mem_addr}, {2'b10, 16'h0010}); end
    @(negedge clk); #1;
    total++; if ({r0_rvalid, r1_rvalid, r0_rdata} !== {2'b10, 16'hBEEF}) begin bad++; $display("[TB] FAIL rd_resp got=%h want=%h", {r0_rvalid, r1_rvalid, r0_rdata}, {2'b10, 16'hBEEF}); end
    @(negedge clk); #1;
    total++; if ({r0_rvalid, mem_en} !== 2'b00) begin bad++; $display("[TB] FAIL rd_done got=%b want=00", {r0_rvalid, mem_en}); end
  endtask

  task automatic test_write();
    @(negedge clk);
    r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 16'hFFFF; r1_wdata = 16'h1234; r1_lock = 1'b0; #1;
    total++; if ({r0_ready, r1_ready} !== 2'b01) begin bad++; $display("[TB] FAIL wr_accept got=%b want=01", {r0_ready, r1_ready}); end
    @(negedge clk);
    r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = 16'hAAAA; #1;
    total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'hFFFF, 16'h1234}) begin bad++; $display("[TB] FAIL wr_issue got=%h want=%h", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 16'hFFFF, 16'h1234}); end
    @(negedge clk);
    r0_valid = 1'b1; r0_addr = 16'hFFFF; #1;
    total++; if ({r1_rvalid, r0_rvalid, r1_rdata} !== {2'b10, 16'h0000}) begin bad++; $display("[TB] FAIL wr_ack got=%h want=%h", {r1_rvalid, r0_rvalid, r1_rdata}, {2'b10, 16'h0000}); end
    total++; if ({r0_ready, r1_ready} !== 2'b10) begin bad++; $display("[TB] FAIL rb_accept got=%b want=10", {r0_ready, r1_ready}); end
    @(negedge clk);
    r0_valid = 1'b0; #1;
    total++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'hFFFF}) begin bad++; $display("[TB] FAIL rb_issue got=%h want=%h", {mem_en, mem_we, mem_addr}, {2'b10, 16'hFFFF}); end
    @(negedge clk); #1;
    total++; if ({r0_rvalid, r0_rdata} !== {1'b1, 16'h1234}) begin bad++; $display("[TB] FAIL rb_resp got=%h want=%h", {r0_rvalid, r0_rdata}, {1'b1, 16'h1234}); end
  endtask

  task automatic test_lock();
    @(negedge clk);
    r0_valid = 1'b1; r0_addr = 16'h0020;
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 16'h0030; r1_lock = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      total++; if ({r0_ready, r1_ready} !== 2'b01) begin bad++; $display("[TB] FAIL lock_grant%0d got=%b want=01", k, {r0_ready, r1_ready}); end
      @(negedge clk);
      if (k == 2) r1_valid = 1'b0;
      #1;
      total++; if ({r0_ready, r1_ready, mem_en, mem_addr} !== {3'b001, 16'h0030}) begin bad++; $display("[TB] FAIL lock_issue%0d got=%h", k, {r0_ready, r1_ready, mem_en, mem_addr}); end
      @(negedge clk); #1;
    end
    total++; if ({r0_ready, r1_ready, r1_rvalid} !== 3'b001) begin bad++; $display("[TB] FAIL lock_hold_resp got=%b want=001", {r0_ready, r1_ready, r1_rvalid}); end
    @(negedge clk); #1;
    total++; if ({r0_ready, r1_ready} !== 2'b00) begin bad++; $display("[TB] FAIL lock_hold_idle got=%b want=00", {r0_ready, r1_ready}); end
    r1_lock = 1'b0; #1;
    total++; if ({r0_ready, r1_ready} !== 2'b10) begin bad++; $display("[TB] FAIL lock_release got=%b want=10", {r0_ready, r1_ready}); end
    @(negedge clk);
    r0_valid = 1'b0; #1;
    total++; if ({mem_en, mem_addr} !== {1'b1, 16'h0020}) begin bad++; $display("[TB] FAIL lock_r0_issue got=%h want=%h", {mem_en, mem_addr}, {1'b1, 16'h0020}); end
    @(negedge clk); #1;
    total++; if ({r0_rvalid, lock_err} !== 2'b10) begin bad++; $display("[TB] FAIL lock_r0_resp got=%b want=10", {r0_rvalid, lock_err}); end
  endtask

  task automatic test_lock_timeout();
    @(negedge clk);
    r1_valid = 1'b1; r1_lock = 1'b1; r1_we = 1'b0; r1_addr = 16'h0050; r0_valid = 1'b0; #1;
    total++; if ({r0_ready, r1_ready} !== 2'b01) begin bad++; $display("[TB] FAIL to_accept got=%b want=01", {r0_ready, r1_ready}); end
    @(negedge clk);
    r1_valid = 1'b0; r0_valid = 1'b1; r0_addr = 16'h0040; #1;
    for (int c = 2; c <= LM; c++) begin
      @(negedge clk); #1;
      total++; if ({r0_ready, r1_ready, lock_err} !== 3'b000) begin bad++; $display("[TB] FAIL to_wait%0d got=%b want=000", c, {r0_ready, r1_ready, lock_err}); end
    end
    @(negedge clk); #1;
    total++; if ({r0_ready, lock_err} !== 2'b11) begin bad++; $display("[TB] FAIL to_release got=%b want=11", {r0_ready, lock_err}); end
    @(negedge clk);
    r0_valid = 1'b0; r1_valid = 1'b1; r1_addr = 16'h0051; #1;
    @(negedge clk); #1;
    total++; if ({r0_rvalid, r1_ready} !== 2'b11) begin bad++; $display("[TB] FAIL to_r1_grant got=%b want=11", {r0_rvalid, r1_ready}); end
    @(negedge clk);
    r1_valid = 1'b0; r0_valid = 1'b1; #1;
    @(negedge clk); #1;
    total++; if ({r1_rvalid, r0_ready, r1_ready} !== 3'b110) begin bad++; $display("[TB] FAIL to_ignored got=%b want=110", {r1_rvalid, r0_ready, r1_ready}); end
    @(negedge clk);
    r0_valid = 1'b0; r1_lock = 1'b0; #1;
    @(negedge clk); #1;
    total++; if ({r0_rvalid, lock_err} !== 2'b11) begin bad++; $display("[TB] FAIL to_sticky got=%b want=11", {r0_rvalid, lock_err}); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    r0_valid = 1'b1; r0_addr = 16'h0010; #1;
    total++; if (r0_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_accept got=%b want=1", r0_ready); end
    @(negedge clk); #1;
    total++; if (mem_en !== 1'b1) begin bad++; $display("[TB] FAIL mid_issue got=%b want=1", mem_en); end
    rst_n = 1'b0; #1;
    total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== 34'h0) begin bad++; $display("[TB] FAIL mid_mem got=%h want=0", {mem_en, mem_we, mem_addr, mem_wdata}); end
    total++; if ({r0_rvalid, r1_rvalid, lock_err, r0_ready, r1_ready} !== 5'b0) begin bad++; $display("[TB] FAIL mid_flags got=%b want=00000", {r0_rvalid, r1_rvalid, lock_err, r0_ready, r1_ready}); end
    r0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; #1;
    for (int c = 0; c < 3; c++) begin
      total++; if ({r0_rvalid, r1_rvalid, mem_en} !== 3'b000) begin bad++; $display("[TB] FAIL mid_quiet%0d got=%b want=000", c, {r0_rvalid, r1_rvalid, mem_en}); end
      @(negedge clk); #1;
    end
    r0_valid = 1'b1; r0_addr = 16'h0010; r1_valid = 1'b1; r1_addr = 16'h0020; #1;
    total++; if ({r0_ready, r1_ready} !== 2'b10) begin bad++; $display("[TB] FAIL mid_ptr got=%b want=10", {r0_ready, r1_ready}); end
    @(negedge clk);
    r0_valid = 1'b0; r1_valid = 1'b0; #1;
    @(negedge clk); #1;
    total++; if ({r0_rvalid, r0_rdata} !== {1'b1, 16'hBEEF}) begin bad++; $display("[TB] FAIL mid_reread got=%h want=%h", {r0_rvalid, r0_rdata}, {1'b1, 16'hBEEF}); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_write();
    test_lock();
    test_lock_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, 16, address width in bits.
REQ-002 SHALL have parameter DW, 16, data width in bits.
REQ-003 SHALL have parameter LOCK_MAX, 64, maximum number of cycles a lock may be held (range 2..65535).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports r0_valid in 1, r0_addr in AW, r0_ready out 1, r0_rvalid out 1, r0_rdata out DW  requester 0 (instruction fetch), read-only.
REQ-007 SHALL have ports r1_valid in 1, r1_we in 1, r1_addr in AW, r1_wdata in DW, r1_lock in 1, r1_ready out 1, r1_rvalid out 1, r1_rdata out DW  requester 1 (data/stack).
REQ-008 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW, mem_rdata in DW  single-port synchronous RAM; rdata is valid the cycle after mem_en.
REQ-009 SHALL have port lock_err  out  1  sticky flag set when a lock is forcibly released.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, RESP; reset state is IDLE.
REQ-011 Arbitration points are IDLE and RESP. At an arbitration point with any rN_valid high, the arbiter SHALL pick one winner, assert rN_ready combinationally that cycle, latch addr/we/wdata, and go to ISSUE. With no valid request it SHALL go to (or stay in) IDLE.
REQ-012 rN_ready SHALL be asserted only for the winner, only at an arbitration point, and never for both requesters in the same cycle.
REQ-013 ISSUE SHALL drive mem_en=1 with the latched mem_we/mem_addr/mem_wdata for exactly one cycle, then go to RESP.
REQ-014 RESP SHALL pulse the winner's rN_rvalid for one cycle; reads: rN_rdata=mem_rdata; writes: rN_rdata=0 (rvalid serves as write ack).
REQ-015 Latency: acceptance at cycle T, mem_en at T+1, rvalid at T+2. Back-to-back acceptance in RESP SHALL give one transaction per 2 cycles.
REQ-016 r0 requests SHALL drive mem_we=0 regardless of other inputs.
REQ-017 Contention SHALL be resolved round-robin: grant the requester not granted last. Last-grant pointer reset value = 1, so r0 wins the first contention.
REQ-018 A single valid requester SHALL always win, irrespective of the pointer (no locking).
REQ-019 If r1 is accepted with r1_lock=1, the arbiter SHALL enter locked mode: at later arbitration points only r1 may be granted; r0 waits even if r1_valid=0.
REQ-020 Locked mode SHALL end at the first arbitration point where r1_lock=0 is sampled; that point arbitrates normally.
REQ-021 A lock counter SHALL count every cycle in locked mode. On reaching LOCK_MAX it SHALL leave locked mode and set lock_err=1.
REQ-022 After a forced release, r1_lock SHALL be ignored until it has been sampled low at least once.
REQ-023 lock_err SHALL clear only on reset.
REQ-024 rN_valid dropping after acceptance SHALL NOT affect the transaction in flight. rN_addr/rN_wdata SHALL be sampled only on the acceptance cycle.
REQ-025 Address SHALL pass unmodified; there is no wrap-around or range checking (0xFFFF is legal).

Reset
REQ-026 rst_n low SHALL force, immediately and independent of clk: state=IDLE, pointer=1, lock mode off, lock counter=0, lock_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, r0/r1_ready=0, r0/r1_rvalid=0, r0/r1_rdata=0.
REQ-027 Reset asserted mid-transaction SHALL abort it; no rvalid SHALL follow and no write SHALL be issued after rst_n rises unless re-requested.
REQ-028 The first arbitration SHALL occur on the first rising clk edge with rst_n high.

Verification
REQ-029 Single read: r0 addr 0x0010 at T, RAM[0x0010]=0xBEEF -> r0_ready at T, mem_en/addr 0x0010/we=0 at T+1, r0_rvalid with rdata 0xBEEF at T+2.
REQ-030 Contention: both valid continuously after reset -> grants alternate r0,r1,r0,r1, with a ready every 2 cycles.
REQ-031 Write: r1 we=1, addr 0xFFFF, wdata 0x1234 -> mem_we=1, addr 0xFFFF, wdata 0x1234 at T+1, r1_rvalid with rdata 0 at T+2; a subsequent read of 0xFFFF returns 0x1234.
REQ-032 Lock: r1 locked for 3 transactions while r0 is valid -> r0 gets no ready until r1_lock=0 is sampled, then r0 is granted.
REQ-033 Lock timeout: LOCK_MAX=8, r1_lock held high -> release after 8 cycles, lock_err=1, r0 granted next, r1_lock ignored until it goes low.
REQ-034 Reset mid-transaction: rst_n low during ISSUE -> all outputs 0 at once, no rvalid afterwards, lock_err=0.
